// File: rtl/cix32_mem_pkg.sv
// Shared types and helpers for the CIX-32 memory responder: FSM encoding,
// request kinds and byte-address to word-index conversion.
package cix32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef logic [1:0] req_kind_t;

  localparam req_kind_t REQ_RD  = 2'd0;
  localparam req_kind_t REQ_WR  = 2'd1;
  localparam req_kind_t REQ_ERR = 2'd2;

  // Drops the byte offset; callers truncate to their own index width.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Simultaneous read and write requests are a protocol error.
  function automatic req_kind_t req_kind(input logic re, input logic we);
    req_kind_t kind;
    if (re && we) begin
      kind = REQ_ERR;
    end else if (we) begin
      kind = REQ_WR;
    end else begin
      kind = REQ_RD;
    end
    return kind;
  endfunction

endpackage

// File: rtl/cix32_sram_1rw.sv
// Synchronous single-port word RAM; read data is registered and holds until
// the next read. Contents are deliberately not reset.
module cix32_sram_1rw #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Single access per cycle: write, or registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= wdata;
      end else begin
        rdata_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/cix32_mem_responder.sv
// Slave end of the CIX-32 memory handshake: serves core reads/writes from a
// word SRAM after a programmable wait-state count, plus a backdoor load port.
module cix32_mem_responder
  import cix32_mem_pkg::*;
#(
  parameter int          ADDR_WORDS = 1024,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] ERR_RDATA  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_re,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        bus_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int          AW       = $clog2(ADDR_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * ADDR_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [AW-1:0] idx_r;
  logic [31:0] wdata_r;
  req_kind_t   kind_r;
  logic        in_range_r;
  logic        ready_r;
  logic        err_r;
  logic        busy_r;
  logic        sel_sram_r;
  logic [31:0] rdata_r;

  logic        req_s;
  logic        accept_s;
  logic        fire_s;
  req_kind_t   cur_kind_s;
  logic        cur_in_range_s;
  logic [AW-1:0] cur_idx_s;
  logic [31:0] cur_wdata_s;
  logic        cur_ok_s;
  logic        load_ok_s;
  logic        sram_en_s;
  logic        sram_we_s;
  logic [AW-1:0] sram_addr_s;
  logic [31:0] sram_wdata_s;
  logic [31:0] sram_rdata_s;

  // Current transaction view: live inputs on the accept edge, latched values afterwards.
  always_comb begin
    req_s    = mem_re | mem_we;
    accept_s = (state_r == ST_IDLE) && req_s;
    if (accept_s) begin
      cur_kind_s     = req_kind(mem_re, mem_we);
      cur_in_range_s = (mem_addr < SPAN);
      cur_idx_s      = AW'(word_index(mem_addr));
      cur_wdata_s    = mem_wdata;
    end else begin
      cur_kind_s     = kind_r;
      cur_in_range_s = in_range_r;
      cur_idx_s      = idx_r;
      cur_wdata_s    = wdata_r;
    end
    // fire_s marks the edge that enters RESP; SRAM access happens on that edge.
    fire_s    = (accept_s && (LATENCY == 0)) ||
                ((state_r == ST_WAIT) && (cnt_r == 4'd0) && req_s);
    cur_ok_s  = cur_in_range_s && (cur_kind_s != REQ_ERR);
    load_ok_s = (state_r == ST_IDLE) && !req_s && load_en && (load_addr < SPAN);
  end

  // SRAM port arbitration: core transaction first, then backdoor.
  always_comb begin
    if (fire_s && cur_ok_s) begin
      sram_en_s    = 1'b1;
      sram_we_s    = (cur_kind_s == REQ_WR);
      sram_addr_s  = cur_idx_s;
      sram_wdata_s = cur_wdata_s;
    end else if (load_ok_s) begin
      sram_en_s    = 1'b1;
      sram_we_s    = 1'b1;
      sram_addr_s  = AW'(word_index(load_addr));
      sram_wdata_s = load_data;
    end else begin
      sram_en_s    = 1'b0;
      sram_we_s    = 1'b0;
      sram_addr_s  = {AW{1'b0}};
      sram_wdata_s = 32'h0000_0000;
    end
  end

  cix32_sram_1rw #(
    .DEPTH (ADDR_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en_s),
    .we    (sram_we_s),
    .addr  (sram_addr_s),
    .wdata (sram_wdata_s),
    .rdata (sram_rdata_s)
  );

  // Transaction FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      idx_r      <= {AW{1'b0}};
      wdata_r    <= 32'h0000_0000;
      kind_r     <= REQ_RD;
      in_range_r <= 1'b0;
      ready_r    <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      sel_sram_r <= 1'b0;
      rdata_r    <= 32'h0000_0000;
    end else begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            kind_r     <= cur_kind_s;
            in_range_r <= cur_in_range_s;
            idx_r      <= cur_idx_s;
            wdata_r    <= cur_wdata_s;
            busy_r     <= 1'b1;
            if (LATENCY == 0) begin
              state_r <= ST_RESP;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= CNT_INIT;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!req_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
          end else if (cnt_r == 4'd0) begin
            state_r <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Core may still hold its request for a cycle after mem_ready.
          if (!req_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      if (fire_s) begin
        ready_r <= 1'b1;
        err_r   <= !cur_ok_s;
        if (cur_kind_s != REQ_WR) begin
          if (cur_ok_s) begin
            sel_sram_r <= 1'b1;
          end else begin
            sel_sram_r <= 1'b0;
            rdata_r    <= ERR_RDATA;
          end
        end
      end
    end
  end

  // SRAM read data stays valid until the next read completion, so it can be shown directly.
  assign mem_rdata = sel_sram_r ? sram_rdata_s : rdata_r;
  assign mem_ready = ready_r;
  assign bus_err   = err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_cix32_mem_responder.sv
// Directed self-checking bench for cix32_mem_responder (LATENCY=2).
module tb_cix32_mem_responder;

  localparam logic [31:0] ERR = 32'hE0E0_E0E0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, mem_ready, bus_err;
  logic        load_en;
  logic [31:0] load_addr, load_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cix32_mem_responder #(
    .ADDR_WORDS (1024),
    .LATENCY    (2),
    .ERR_RDATA  (ERR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .bus_err   (bus_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
  );

  task automatic bd_load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // One core transaction; request held one cycle past mem_ready, then dropped.
  task automatic xfer(input logic re, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic bd_in_resp,
                      output logic [31:0] rd, output logic err, output int lat,
                      output logic pulse_ok, output logic drain_ok, output logic idle_ok);
    @(negedge clk);
    mem_re = re; mem_we = we; mem_addr = a; mem_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ready && lat < 20);
    checks++;
    if (!mem_ready) begin
      errors++;
      $display("FAIL xfer_timeout addr=%h: mem_ready never rose within %0d cycles", a, lat);
    end
    rd  = mem_rdata;
    err = bus_err;
    if (bd_in_resp) begin
      load_en = 1'b1; load_addr = a; load_data = 32'hBEEF_0000;
    end
    @(negedge clk);
    load_en  = 1'b0;
    pulse_ok = !mem_ready && !bus_err;
    @(negedge clk);
    drain_ok = !mem_ready && busy;
    mem_re = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    idle_ok = !busy && !mem_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_re = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;
    #12;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", mem_ready); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus_err); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", mem_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_latency();
    logic [31:0] rd; logic err, p, d, i; int lat;
    bd_load(32'h0, 32'h0000_00B8);
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
    checks++; if (rd !== 32'h0000_00B8) begin errors++; $display("FAIL rd_data: got %h want 000000b8", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", err); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL rd_pulse_one_cycle: got %b want 1", p); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL rd_drain_no_reserve: got %b want 1", d); end
    checks++; if (i !== 1'b1) begin errors++; $display("FAIL rd_back_idle: got %b want 1", i); end
  endtask

  task automatic test_write_readback();
    logic [31:0] rd; logic err, p, d, i; int lat;
    xfer(1'b0, 1'b1, 32'h10, 32'h1234_5678, 1'b0, rd, err, lat, p, d, i);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", err); end
    checks++; if (rd !== 32'h0000_00B8) begin errors++; $display("FAIL wr_rdata_hold: got %h want 000000b8", rd); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL wr_drain_no_reserve: got %b want 1", d); end
    xfer(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL wr_readback_0x13: got %h want 12345678", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err, p, d, i; int lat;
    xfer(1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", err); end
    checks++; if (rd !== ERR) begin errors++; $display("FAIL oor_rd_data: got %h want %h", rd, ERR); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_rd_latency: got %0d want 3", lat); end
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (rd !== 32'h0000_00B8 || err !== 1'b0) begin errors++; $display("FAIL oor_then_read: got %h err=%b want 000000b8 err=0", rd, err); end
    xfer(1'b0, 1'b1, 32'h1010, 32'hDEAD_BEEF, 1'b0, rd, err, lat, p, d, i);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", err); end
    checks++; if (rd !== 32'h0000_00B8) begin errors++; $display("FAIL oor_wr_rdata_hold: got %h want 000000b8", rd); end
    bd_load(32'h1010, 32'h0BAD_0BAD);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL oor_no_alias_0x10: got %h want 12345678", rd); end
  endtask

  task automatic test_protocol_err();
    logic [31:0] rd; logic err, p, d, i; int lat;
    bd_load(32'h20, 32'hA5A5_0020);
    xfer(1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 1'b0, rd, err, lat, p, d, i);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL proto_err: got %b want 1", err); end
    checks++; if (rd !== ERR) begin errors++; $display("FAIL proto_rdata: got %h want %h", rd, ERR); end
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (rd !== 32'hA5A5_0020) begin errors++; $display("FAIL proto_no_write: got %h want a5a50020", rd); end
  endtask

  task automatic test_latched_addr();
    logic [31:0] rd; logic err, p, d, i; int lat; int n;
    bd_load(32'h54, 32'h5454_5454);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 32'h50; mem_wdata = 32'h5050_5050;
    @(negedge clk);
    mem_addr = 32'h54; mem_wdata = 32'hFFFF_FFFF;
    n = 0;
    while (!mem_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (!mem_ready) begin errors++; $display("FAIL latch_timeout: no mem_ready after %0d cycles", n); end
    @(negedge clk);
    @(negedge clk);
    mem_we = 1'b0;
    @(negedge clk);
    xfer(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (rd !== 32'h5050_5050) begin errors++; $display("FAIL latch_wr_0x50: got %h want 50505050", rd); end
    xfer(1'b1, 1'b0, 32'h54, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (rd !== 32'h5454_5454) begin errors++; $display("FAIL latch_0x54_untouched: got %h want 54545454", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err, p, d, i; int lat; logic saw_ready;
    bd_load(32'h30, 32'h3030_3030);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 32'h30; mem_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_wait: got %b want 1", busy); end
    mem_we = 1'b0;
    saw_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      saw_ready = saw_ready | mem_ready;
    end
    checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got %b want 0", saw_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_low: got %b want 0", busy); end
    xfer(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (rd !== 32'h3030_3030) begin errors++; $display("FAIL abort_no_write: got %h want 30303030", rd); end
  endtask

  task automatic test_load_in_resp();
    logic [31:0] rd; logic err, p, d, i; int lat;
    bd_load(32'h60, 32'h6060_6060);
    xfer(1'b1, 1'b0, 32'h60, 32'h0, 1'b1, rd, err, lat, p, d, i);
    checks++; if (rd !== 32'h6060_6060) begin errors++; $display("FAIL resp_read: got %h want 60606060", rd); end
    xfer(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (rd !== 32'h6060_6060) begin errors++; $display("FAIL resp_load_ignored: got %h want 60606060", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err, p, d, i; int lat;
    bd_load(32'h40, 32'h4040_4040);
    @(negedge clk);
    mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hFFFF_0000;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", mem_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 0", mem_rdata); end
    mem_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rd, err, lat, p, d, i);
    checks++; if (rd !== 32'h4040_4040) begin errors++; $display("FAIL rstmid_no_write: got %h want 40404040", rd); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_readback();
    test_out_of_range();
    test_protocol_err();
    test_latched_addr();
    test_abort();
    test_load_in_resp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
